// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Circular-buffer instruction queue between the instruction SRAM and decode.
//   Each entry holds a PC and an instruction word. An entry pushed into an
//   empty queue is visible to decode on the very next cycle, because the head
//   entry is read combinationally from the storage array.
//
// Ports
//   clk             : single clock, all state updates on the rising edge
//   reset           : asynchronous active-high reset (clears pointers/count)
//   execption       : flush request; discards all entries and same-cycle input
//   in_valid        : PC/instruction pair on the SRAM side is valid
//   in_ready        : queue has room (count < DEPTH); ignores out_ready
//   inst_sram_raddr : PC of the incoming instruction
//   inst_sram_rdata : incoming instruction word
//   out_valid       : head entry is valid (count != 0)
//   out_ready       : decode accepts the head entry; low means stall
//   fe_pc           : head PC, or RESET_PC when empty
//   fe_inst         : head instruction, or RESET_INST when empty
//   fe_count        : number of occupied entries
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int          DEPTH      = 4,
    parameter int          DATA_W     = 32,
    parameter logic [31:0] RESET_PC   = 32'hbfc00000,
    parameter logic [31:0] RESET_INST = 32'h00000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       execption,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                inst_sram_raddr,
    input  logic [DATA_W-1:0]          inst_sram_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                fe_pc,
    output logic [DATA_W-1:0]          fe_inst,
    output logic [$clog2(DEPTH):0]     fe_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    // Storage: no reset on the array, only the bookkeeping is cleared.
    logic [31:0]       r_pc_mem   [DEPTH];
    logic [DATA_W-1:0] r_inst_mem [DEPTH];

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_wptr_inc;
    logic [PW-1:0] w_rptr_inc;

    assign w_in_ready  = (r_count < DEPTH_C);
    assign w_out_valid = (r_count != '0);

    // A flush overrides both handshakes so nothing is written or consumed.
    assign w_push = in_valid  & w_in_ready  & ~execption;
    assign w_pop  = out_ready & w_out_valid & ~execption;

    // Explicit wrap keeps the intent obvious even though DEPTH is a power of two.
    assign w_wptr_inc = (r_wptr == LAST_C) ? '0 : r_wptr + PW'(1);
    assign w_rptr_inc = (r_rptr == LAST_C) ? '0 : r_rptr + PW'(1);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wptr]   <= inst_sram_raddr;
            r_inst_mem[r_wptr] <= inst_sram_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (execption) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= w_wptr_inc;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_inc;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign fe_count  = r_count;
    assign fe_pc     = w_out_valid ? r_pc_mem[r_rptr]   : RESET_PC;
    assign fe_inst   = w_out_valid ? r_inst_mem[r_rptr] : RESET_INST;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int          DEPTH      = 4;
    localparam int          DATA_W     = 32;
    localparam logic [31:0] RESET_PC   = 32'hbfc00000;
    localparam logic [31:0] RESET_INST = 32'h00000000;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   execption;
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            inst_sram_raddr;
    logic [DATA_W-1:0]      inst_sram_rdata;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            fe_pc;
    logic [DATA_W-1:0]      fe_inst;
    logic [$clog2(DEPTH):0] fe_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH      (DEPTH),
        .DATA_W     (DATA_W),
        .RESET_PC   (RESET_PC),
        .RESET_INST (RESET_INST)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .execption       (execption),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .inst_sram_raddr (inst_sram_raddr),
        .inst_sram_rdata (inst_sram_rdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .fe_pc           (fe_pc),
        .fe_inst         (fe_inst),
        .fe_count        (fe_count)
    );

    // Behavioural model: an ordered list of pending entries.
    typedef struct {
        logic [31:0]       pc;
        logic [DATA_W-1:0] inst;
    } ent_t;

    ent_t mq[$];
    bit   m_push;
    bit   m_pop;

    always @(posedge clk or posedge reset) begin
        if (reset || execption) begin
            mq.delete();
        end else begin
            m_push = in_valid && (mq.size() < DEPTH);
            m_pop  = out_ready && (mq.size() != 0);
            if (m_pop)  void'(mq.pop_front());
            if (m_push) mq.push_back('{pc: inst_sram_raddr, inst: inst_sram_rdata});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle compare all DUT outputs with the model.
    always @(negedge clk) begin
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        e_valid = (mq.size() != 0);
        e_pc    = e_valid ? mq[0].pc   : RESET_PC;
        e_inst  = e_valid ? mq[0].inst : RESET_INST;
        chk("model_out_valid", 64'(out_valid), 64'(e_valid));
        chk("model_in_ready",  64'(in_ready),  64'(mq.size() < DEPTH));
        chk("model_fe_count",  64'(fe_count),  64'(mq.size()));
        chk("model_fe_pc",     64'(fe_pc),     64'(e_pc));
        chk("model_fe_inst",   64'(fe_inst),   64'(e_inst));
    end

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]};
    endfunction

    // Drive inputs, then advance one rising edge and settle 1 time unit.
    task automatic step(input logic iv, input logic [31:0] pc, input logic ordy, input logic ex);
        in_valid        = iv;
        inst_sram_raddr = pc;
        inst_sram_rdata = inst_of(pc);
        out_ready       = ordy;
        execption       = ex;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pc;
        reset           = 1'b1;
        execption       = 1'b0;
        in_valid        = 1'b0;
        out_ready       = 1'b0;
        inst_sram_raddr = '0;
        inst_sram_rdata = '0;

        // Reset held 3 cycles, then idle.
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst_fe_pc",     64'(fe_pc),     64'h0000_0000_bfc0_0000);
        chk("rst_fe_inst",   64'(fe_inst),   64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_in_ready",  64'(in_ready),  64'h1);
        chk("rst_fe_count",  64'(fe_count),  64'h0);

        // Fill while stalled; fifth push must be dropped.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'hbfc00000 + 32'(4 * i), 1'b0, 1'b0);
            chk("fill_head_hold", 64'(fe_pc), 64'h0000_0000_bfc0_0000);
        end
        step(1'b1, 32'hbfc00010, 1'b0, 1'b0);
        chk("full_fe_count", 64'(fe_count), 64'h4);
        chk("full_in_ready", 64'(in_ready),  64'h0);
        chk("full_fe_pc",    64'(fe_pc),     64'h0000_0000_bfc0_0000);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            chk("drain_fe_pc", 64'(fe_pc), 64'(32'hbfc00000 + 32'(4 * i)));
            step(1'b0, 32'h0, 1'b1, 1'b0);
        end
        chk("drain_out_valid", 64'(out_valid), 64'h0);
        chk("drain_fe_pc",     64'(fe_pc),     64'h0000_0000_bfc0_0000);

        // Streaming: one in, one out each cycle, count stays 1.
        for (int i = 0; i < 10; i++) begin
            pc = 32'h00400000 + 32'(4 * i);
            step(1'b1, pc, 1'b1, 1'b0);
            chk("stream_fe_count", 64'(fe_count), 64'h1);
            chk("stream_fe_pc",    64'(fe_pc),    64'(pc));
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stream_empty", 64'(out_valid), 64'h0);

        // Flush with count=3 and a same-cycle push.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h00800000 + 32'(4 * i), 1'b0, 1'b0);
        chk("preflush_count", 64'(fe_count), 64'h3);
        step(1'b1, 32'hdead0000, 1'b0, 1'b1);
        chk("flush_fe_count",  64'(fe_count),  64'h0);
        chk("flush_out_valid", 64'(out_valid), 64'h0);
        chk("flush_fe_inst",   64'(fe_inst),   64'h0);
        chk("flush_in_ready",  64'(in_ready),  64'h1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            chk("flush_no_ghost", 64'(out_valid), 64'h0);
        end
        // Flush on an empty queue, then a push must land at the head.
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h00900000, 1'b0, 1'b0);
        chk("postflush_push", 64'(fe_pc), 64'h0000_0000_0090_0000);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle with count=2.
        step(1'b1, 32'h00a00000, 1'b0, 1'b0);
        step(1'b1, 32'h00a00004, 1'b0, 1'b0);
        chk("prereset_count", 64'(fe_count), 64'h2);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_fe_count",  64'(fe_count),  64'h0);
        chk("async_out_valid", 64'(out_valid), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 32'h00b00000, 1'b0, 1'b0);
        chk("first_push_count", 64'(fe_count), 64'h1);
        chk("first_push_pc",    64'(fe_pc),    64'h0000_0000_00b0_0000);

        // Randomized traffic checked by the model process.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
                #1;
                @(posedge clk);
                #1;
                reset = 1'b0;
            end
            step($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 5,
                 $urandom_range(0, 49) == 0);
        end

        repeat (DEPTH + 1) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("final_empty", 64'(out_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, 2..16.
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 Parameter RESET_PC, default 32'hbfc00000, PC presented on fe_pc while the queue is empty.
REQ-004 Parameter RESET_INST, default 32'h00000000, instruction presented on fe_inst while the queue is empty.
REQ-005 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1, asynchronous active-high reset.
REQ-007 Port execption, input, 1, flush request from the exception unit.
REQ-008 Port in_valid, input, 1, the sram pair on inst_sram_raddr/inst_sram_rdata is valid this cycle.
REQ-009 Port in_ready, output, 1, queue can accept an entry this cycle.
REQ-010 Port inst_sram_raddr, input, 32, PC of the incoming instruction.
REQ-011 Port inst_sram_rdata, input, DATA_W, incoming instruction word.
REQ-012 Port out_valid, output, 1, head entry valid toward decode.
REQ-013 Port out_ready, input, 1, decode accepts the head entry; low means stall.
REQ-014 Port fe_pc, output, 32, head entry PC.
REQ-015 Port fe_inst, output, DATA_W, head entry instruction.
REQ-016 Port fe_count, output, $clog2(DEPTH)+1, current number of occupied entries.

Function
REQ-017 Storage is a circular buffer of DEPTH entries with write pointer, read pointer and occupancy count, all registered.
REQ-018 push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated in the same cycle.
REQ-019 in_ready SHALL be high iff fe_count < DEPTH, with no dependence on out_ready (no same-cycle pass-through when full).
REQ-020 out_valid SHALL be high iff fe_count != 0.
REQ-021 fe_pc/fe_inst SHALL equal the entry at the read pointer when out_valid=1, and RESET_PC/RESET_INST when out_valid=0.
REQ-022 Latency: an entry pushed into an empty queue in cycle N SHALL appear on the outputs with out_valid=1 in cycle N+1.
REQ-023 Order: entries SHALL be popped in exactly the order pushed, with no loss or duplication.
REQ-024 Push only: write entry at the write pointer, increment the write pointer and the count.
REQ-025 Pop only: increment the read pointer, decrement the count.
REQ-026 Push and pop together: both pointers advance and the count is unchanged; this is legal at any count from 1 to DEPTH-1.
REQ-027 Pointers wrap modulo DEPTH: DEPTH-1 increments to 0.
REQ-028 While stalled (out_ready=0), the head entry and all outputs SHALL hold stable.
REQ-029 Flush (execption=1) SHALL take priority over push and pop: next cycle count=0, both pointers=0, and the same-cycle input is discarded.
REQ-030 The cycle after a flush, out_valid=0, fe_pc=RESET_PC, fe_inst=RESET_INST, and in_ready=1.
REQ-031 Flush with the queue already empty SHALL be a no-op apart from resetting the pointers.
REQ-032 in_valid while full SHALL be ignored: no write and no pointer change.

Reset
REQ-033 Assertion of reset SHALL immediately, without waiting for clk, clear the count and both pointers.
REQ-034 During and after reset, outputs SHALL be out_valid=0, in_ready=1, fe_count=0, fe_pc=RESET_PC, fe_inst=RESET_INST.
REQ-035 Reset mid-operation SHALL discard all entries; entry contents need not be cleared.
REQ-036 The first push SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-037 Reset then idle: hold reset 3 cycles then release -> fe_pc=32'hbfc00000, fe_inst=0, out_valid=0, in_ready=1, fe_count=0.
REQ-038 Fill with DEPTH=4 and out_ready=0: push PCs bfc00000, bfc00004, bfc00008, bfc0000c -> fe_count=4, in_ready=0, fe_pc holds bfc00000; a fifth push of bfc00010 is dropped.
REQ-039 Drain: from the full queue, raise out_ready for 4 cycles -> fe_pc sequence bfc00000..bfc0000c, then out_valid=0 and fe_pc=bfc00000 (empty value).
REQ-040 Streaming: in_valid=out_ready=1 for 10 cycles with PC +4 each cycle -> fe_count stays 1 after the first cycle, pointers wrap twice, and output order matches input.
REQ-041 Flush with count=3 and in_valid=1 in the same cycle -> next cycle fe_count=0, out_valid=0, fe_inst=0, and the flushed-cycle entry never appears.
REQ-042 Async reset asserted mid-cycle with count=2 -> fe_count=0 and out_valid=0 before the next clk edge.
